// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and defaults for the round-robin shared-adder block.
package adder_share_arbiter_pkg;

   localparam int DEF_N = 32;
   localparam int DEF_R = 4;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // A single requester still needs a one-bit ID field.
   function automatic int idw_of(input int r);
      return (r <= 1) ? 1 : $clog2(r);
   endfunction

endpackage

// File: rtl/adder_share_arbiter_ripple_adder.sv
// N-bit ripple-carry adder without carry-in; purely combinational.
module Ripple_Adder #(
   parameter int N = 32
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] s_o,
   output logic         cout_o
);

   logic c;

   always_comb begin
      s_o = '0;
      c   = 1'b0;
      for (int i = 0; i < N; i++) begin
         s_o[i] = a_i[i] ^ b_i[i] ^ c;
         c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
      end
      cout_o = c;
   end

endmodule

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping; zero latency.
// en_i low suppresses the grant, so the caller owns all backpressure.
module rr_arbiter
   import adder_share_arbiter_pkg::*;
#(
   parameter int  R   = DEF_R,
   localparam int IDW = idw_of(R)
) (
   input  logic [R-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   input  logic           en_i,
   output logic [R-1:0]   gnt_o,
   output logic [IDW-1:0] idx_o
);

   logic [IDW-1:0] kk;
   logic           found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      kk    = '0;
      found = 1'b0;
      for (int off = 0; off < R; off++) begin
         kk = IDW'((int'(ptr_i) + off) % R);
         if (en_i && !found && req_i[kk]) begin
            found     = 1'b1;
            gnt_o[kk] = 1'b1;
            idx_o     = kk;
         end
      end
   end

endmodule

// File: rtl/adder_share_arbiter.sv
// One adder shared by R requesters via round-robin; result lands in a one-entry register 1 cycle after grant.
// Grants only when the register is empty or being drained this cycle, so a stalled consumer freezes all grants.
module adder_share_arbiter
   import adder_share_arbiter_pkg::*;
#(
   parameter int  N   = DEF_N,
   parameter int  R   = DEF_R,
   localparam int IDW = idw_of(R)
) (
   input  logic           i_CLK,
   input  logic           i_RST_n,
   input  logic [R-1:0]   i_req,
   input  logic [R*N-1:0] i_A,
   input  logic [R*N-1:0] i_B,
   output logic [R-1:0]   o_gnt,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [N-1:0]   o_S,
   output logic           o_ovfl,
   output logic [IDW-1:0] o_id
);

   state_t         state_q, state_d;
   logic [IDW-1:0] p_q, p_d;
   logic [IDW-1:0] id_q, id_d;
   logic [N-1:0]   s_q, s_d;
   logic           ovfl_q, ovfl_d;

   logic [IDW-1:0] win_idx;
   logic [N-1:0]   op_a, op_b, sum;
   logic           acc, sum_ovfl, carry_unused;

   // Reset gates the accept so no grant escapes while the block is held in reset.
   assign acc = (|i_req) && ((state_q == ST_EMPTY) || i_ready) && i_RST_n;

   rr_arbiter #(.R(R)) u_arb (
      .req_i (i_req),
      .ptr_i (p_q),
      .en_i  (acc),
      .gnt_o (o_gnt),
      .idx_o (win_idx)
   );

   assign op_a = i_A[int'(win_idx)*N +: N];
   assign op_b = i_B[int'(win_idx)*N +: N];

   Ripple_Adder #(.N(N)) u_add (
      .a_i    (op_a),
      .b_i    (op_b),
      .s_o    (sum),
      .cout_o (carry_unused)
   );

   assign sum_ovfl = (op_a[N-1] & op_b[N-1] & ~sum[N-1]) |
                     (~op_a[N-1] & ~op_b[N-1] & sum[N-1]);

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      s_d     = s_q;
      ovfl_d  = ovfl_q;
      id_d    = id_q;
      if (acc) begin
         state_d = ST_FULL;
         s_d     = sum;
         ovfl_d  = sum_ovfl;
         id_d    = win_idx;
         p_d     = IDW'((int'(win_idx) + 1) % R);
      end else if ((state_q == ST_FULL) && i_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state_q <= ST_EMPTY;
         p_q     <= '0;
         s_q     <= '0;
         ovfl_q  <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         s_q     <= s_d;
         ovfl_q  <= ovfl_d;
         id_q    <= id_d;
      end
   end

   assign o_valid = (state_q == ST_FULL);
   assign o_S     = s_q;
   assign o_ovfl  = ovfl_q;
   assign o_id    = id_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench: driver predicts grants and pushes expected results, monitor checks each presented result.
module tb_adder_share_arbiter;

   localparam int N = 32;
   localparam int R = 4;

   typedef struct {
      logic [31:0] s;
      logic        ovfl;
      logic [1:0]  id;
   } res_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [R-1:0]   i_req;
   logic [R*N-1:0] i_A, i_B;
   logic [R-1:0]   o_gnt;
   logic           o_valid;
   logic           i_ready;
   logic [N-1:0]   o_S;
   logic           o_ovfl;
   logic [1:0]     o_id;

   logic [31:0] op_a [R];
   logic [31:0] op_b [R];
   res_t        exp_q[$];
   int          ptr_m = 0;
   int          vectors = 0;
   int          miscompares = 0;

   adder_share_arbiter #(.N(N), .R(R)) dut (
      .i_CLK   (clk),
      .i_RST_n (rst_n),
      .i_req   (i_req),
      .i_A     (i_A),
      .i_B     (i_B),
      .o_gnt   (o_gnt),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_S     (o_S),
      .o_ovfl  (o_ovfl),
      .o_id    (o_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic res_t model_add(input logic [31:0] a, input logic [31:0] b, input int id);
      res_t   r;
      longint full;
      full   = longint'($signed(a)) + longint'($signed(b));
      r.s    = a + b;
      r.ovfl = (full > 64'sd2147483647) || (full < -64'sd2147483648);
      r.id   = 2'(id);
      return r;
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 6))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Drive one cycle, predict the grant, and queue the result the DUT should load at the edge.
   task automatic drive_cycle(input logic [R-1:0] rq, input logic rdy, output int winner);
      logic [R-1:0] exp_gnt;
      logic         acc_m;
      @(negedge clk);
      i_req   = rq;
      i_ready = rdy;
      for (int k = 0; k < R; k++) begin
         i_A[k*N +: N] = op_a[k];
         i_B[k*N +: N] = op_b[k];
      end
      winner = -1;
      for (int off = 0; off < R; off++) begin
         if (winner < 0 && rq[(ptr_m + off) % R]) winner = (ptr_m + off) % R;
      end
      acc_m   = (rq != 0) && ((exp_q.size() == 0) || rdy);
      exp_gnt = '0;
      if (acc_m) exp_gnt[winner] = 1'b1;
      else winner = -1;
      #1;
      chk("gnt", 64'(o_gnt), 64'(exp_gnt));
      @(posedge clk);
      if (acc_m) begin
         exp_q.push_back(model_add(op_a[winner], op_b[winner], winner));
         ptr_m = (winner + 1) % R;
      end
   endtask

   // Monitor: results sampled mid-cycle; a handshake completes at the following edge.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            chk("valid", 64'(o_valid), 64'(exp_q.size() != 0));
            if (o_valid && exp_q.size() != 0) begin
               chk("sum",  64'(o_S),    64'(exp_q[0].s));
               chk("ovfl", 64'(o_ovfl), 64'(exp_q[0].ovfl));
               chk("id",   64'(o_id),   64'(exp_q[0].id));
               if (i_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int     w;
      logic   pend [R];
      logic [R-1:0] rq;

      rst_n   = 1'b0;
      i_req   = '1;
      i_ready = 1'b1;
      for (int k = 0; k < R; k++) begin
         op_a[k] = $urandom;
         op_b[k] = $urandom;
         i_A[k*N +: N] = op_a[k];
         i_B[k*N +: N] = op_b[k];
      end
      #12;
      chk("rst_gnt",   64'(o_gnt),   64'd0);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_sum",   64'(o_S),     64'd0);
      chk("rst_ovfl",  64'(o_ovfl),  64'd0);
      chk("rst_id",    64'(o_id),    64'd0);
      @(negedge clk);
      i_req = '0;
      rst_n = 1'b1;

      drive_cycle(4'hF, 1'b1, w);

      op_a[2] = 32'd5;
      op_b[2] = 32'd7;
      drive_cycle(4'b0100, 1'b1, w);

      repeat (5) drive_cycle(4'hF, 1'b1, w);

      repeat (3) drive_cycle(4'b0011, 1'b0, w);
      drive_cycle(4'b0011, 1'b1, w);
      drive_cycle(4'b0011, 1'b1, w);

      op_a[0] = 32'h7FFF_FFFF; op_b[0] = 32'h0000_0001;
      drive_cycle(4'b0001, 1'b1, w);
      op_a[0] = 32'h8000_0000; op_b[0] = 32'h8000_0000;
      drive_cycle(4'b0001, 1'b1, w);
      op_a[0] = 32'hFFFF_FFFF; op_b[0] = 32'h0000_0001;
      drive_cycle(4'b0001, 1'b1, w);
      drive_cycle(4'b0000, 1'b1, w);

      // Park a result from req2 (pointer moves to 3), then reset mid-cycle under backpressure.
      drive_cycle(4'b0100, 1'b0, w);
      @(negedge clk);
      i_req   = 4'hF;
      i_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(o_valid), 64'd0);
      chk("midrst_gnt",   64'(o_gnt),   64'd0);
      exp_q.delete();
      ptr_m = 0;
      @(negedge clk);
      i_req = '0;
      rst_n = 1'b1;
      drive_cycle(4'hF, 1'b1, w);

      for (int k = 0; k < R; k++) pend[k] = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int k = 0; k < R; k++) begin
            if (!pend[k] && $urandom_range(0, 9) < 4) begin
               pend[k] = 1'b1;
               op_a[k] = rand_op();
               op_b[k] = rand_op();
            end else if (pend[k] && $urandom_range(0, 19) == 0) begin
               pend[k] = 1'b0;
            end
            rq[k] = pend[k];
         end
         drive_cycle(rq, ($urandom_range(0, 9) < 7), w);
         if (w >= 0) pend[w] = 1'b0;
      end

      drive_cycle(4'b0000, 1'b1, w);
      drive_cycle(4'b0000, 1'b1, w);
      @(negedge clk);
      #3;
      chk("drained_valid", 64'(o_valid), 64'd0);
      chk("drained_queue", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
